// File: rtl/flag_unit_pkg.sv
// Shared constants for the NZCV flag unit and any unit that evaluates
// instruction condition codes (e.g. a future branch unit).
package flag_unit_pkg;

  localparam int NZCV_W = 4;

  // Flag bit positions, matching the ALU NZCV output order
  localparam int F_N = 3;
  localparam int F_Z = 2;
  localparam int F_C = 1;
  localparam int F_V = 0;

  // Instruction condition field encodings
  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

endpackage

// File: rtl/cond_eval.sv
// Pure combinational condition-code evaluator: (cond, nzcv) -> pass.
module cond_eval
  import flag_unit_pkg::*;
(
  input  logic [3:0]        i_cond,
  input  logic [NZCV_W-1:0] i_nzcv,
  output logic              o_pass
);

  logic w_n;
  logic w_z;
  logic w_c;
  logic w_v;

  assign w_n = i_nzcv[F_N];
  assign w_z = i_nzcv[F_Z];
  assign w_c = i_nzcv[F_C];
  assign w_v = i_nzcv[F_V];

  // Decode the condition field against the supplied flags
  always_comb begin
    o_pass = 1'b0;
    case (i_cond)
      COND_EQ: o_pass = w_z;
      COND_NE: o_pass = ~w_z;
      COND_CS: o_pass = w_c;
      COND_CC: o_pass = ~w_c;
      COND_MI: o_pass = w_n;
      COND_PL: o_pass = ~w_n;
      COND_VS: o_pass = w_v;
      COND_VC: o_pass = ~w_v;
      COND_HI: o_pass = w_c & ~w_z;
      COND_LS: o_pass = ~w_c | w_z;
      COND_GE: o_pass = (w_n == w_v);
      COND_LT: o_pass = (w_n != w_v);
      COND_GT: o_pass = ~w_z & (w_n == w_v);
      COND_LE: o_pass = w_z | (w_n != w_v);
      COND_AL: o_pass = 1'b1;
      COND_NV: o_pass = 1'b0;
      default: o_pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_unit.sv
// Architectural NZCV flag register with condition evaluation and a small
// save/restore stack for exception entry/return.
module flag_unit
  import flag_unit_pkg::*;
#(
  parameter int unsigned       DEPTH     = 4,
  parameter logic [NZCV_W-1:0] RST_FLAGS = 4'b0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NZCV_W-1:0] alu_nzcv,
  input  logic              flag_we,
  input  logic              msr_we,
  input  logic [NZCV_W-1:0] msr_data,
  input  logic              push,
  input  logic              pop,
  input  logic              err_clr,
  input  logic [3:0]        cond,
  input  logic              cond_valid,
  output logic [NZCV_W-1:0] nzcv_q,
  output logic              c_out,
  output logic              v_out,
  output logic              cond_pass,
  output logic              exec_en_q,
  output logic              stack_full,
  output logic              stack_empty,
  output logic              stack_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] L_DEPTH = CNT_W'(DEPTH);

  logic [NZCV_W-1:0] r_nzcv;
  logic [NZCV_W-1:0] r_mem [DEPTH];
  logic [CNT_W-1:0]  r_count;
  logic              r_err;
  logic              r_exec;

  logic              w_full;
  logic              w_empty;
  logic              w_push_ok;
  logic              w_pop_ok;
  logic              w_err_evt;
  logic [PTR_W-1:0]  w_wr_idx;
  logic [PTR_W-1:0]  w_top_idx;
  logic [NZCV_W-1:0] w_nzcv_nxt;
  logic              w_pass;

  assign w_full    = (r_count == L_DEPTH);
  assign w_empty   = (r_count == '0);
  assign w_push_ok = push & ~pop & ~w_full;
  assign w_pop_ok  = pop & ~push & ~w_empty;
  assign w_err_evt = (push & pop) | (push & ~pop & w_full) | (pop & ~push & w_empty);

  // Low bits suffice: a write only happens below DEPTH, and a read only
  // above zero, where count-1 wraps correctly within PTR_W bits.
  assign w_wr_idx  = r_count[PTR_W-1:0];
  assign w_top_idx = r_count[PTR_W-1:0] - PTR_W'(1);

  cond_eval u_cond_eval (
    .i_cond (cond),
    .i_nzcv (r_nzcv),
    .o_pass (w_pass)
  );

  // Flag next-value priority: software write, restore, ALU update, hold
  always_comb begin
    w_nzcv_nxt = r_nzcv;
    if (msr_we) begin
      w_nzcv_nxt = msr_data;
    end else if (w_pop_ok) begin
      w_nzcv_nxt = r_mem[w_top_idx];
    end else if (flag_we) begin
      w_nzcv_nxt = alu_nzcv;
    end
  end

  // Flag register, stack count, sticky error and registered execute enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nzcv  <= RST_FLAGS;
      r_count <= '0;
      r_err   <= 1'b0;
      r_exec  <= 1'b0;
    end else begin
      r_nzcv <= w_nzcv_nxt;
      r_exec <= cond_valid & w_pass;
      if (w_push_ok) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_pop_ok) begin
        r_count <= r_count - CNT_W'(1);
      end
      if (w_err_evt) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  // Stack storage saves the pre-update flags; contents are not reset
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[w_wr_idx] <= r_nzcv;
    end
  end

  assign nzcv_q      = r_nzcv;
  assign c_out       = r_nzcv[F_C];
  assign v_out       = r_nzcv[F_V];
  assign cond_pass   = w_pass;
  assign exec_en_q   = r_exec;
  assign stack_full  = w_full;
  assign stack_empty = w_empty;
  assign stack_err   = r_err;

endmodule

// File: tb/tb_flag_unit.sv
// Self-checking bench for flag_unit: behavioural model compared every cycle,
// plus directed literal expectations.
module tb_flag_unit;

  localparam int unsigned DEPTH = 4;
  localparam logic [3:0] RSTF = 4'b0000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] alu_nzcv = '0;
  logic       flag_we = 1'b0;
  logic       msr_we = 1'b0;
  logic [3:0] msr_data = '0;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic       err_clr = 1'b0;
  logic [3:0] cond = '0;
  logic       cond_valid = 1'b0;
  logic [3:0] nzcv_q;
  logic       c_out, v_out, cond_pass, exec_en_q;
  logic       stack_full, stack_empty, stack_err;

  int total = 0;
  int bad = 0;

  flag_unit #(.DEPTH(DEPTH), .RST_FLAGS(RSTF)) dut (
    .clk(clk), .rst_n(rst_n), .alu_nzcv(alu_nzcv), .flag_we(flag_we),
    .msr_we(msr_we), .msr_data(msr_data), .push(push), .pop(pop),
    .err_clr(err_clr), .cond(cond), .cond_valid(cond_valid),
    .nzcv_q(nzcv_q), .c_out(c_out), .v_out(v_out), .cond_pass(cond_pass),
    .exec_en_q(exec_en_q), .stack_full(stack_full),
    .stack_empty(stack_empty), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [3:0] m_flags = RSTF;
  logic [3:0] m_stack[$];
  logic       m_err = 1'b0;
  logic       m_exec = 1'b0;

  function automatic logic cond_true(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'h0: return z;           4'h1: return !z;
      4'h2: return cy;          4'h3: return !cy;
      4'h4: return n;           4'h5: return !n;
      4'h6: return v;           4'h7: return !v;
      4'h8: return cy && !z;    4'h9: return !cy || z;
      4'hA: return n == v;      4'hB: return n != v;
      4'hC: return !z && n == v; 4'hD: return z || n != v;
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always @(negedge rst_n) begin
    m_flags = RSTF;
    m_stack.delete();
    m_err = 1'b0;
    m_exec = 1'b0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      logic [3:0] nf;
      logic [3:0] popped;
      bit do_pop, evt;
      nf = m_flags; do_pop = 0; evt = 0; popped = '0;
      if (push && pop) evt = 1;
      else if (push) begin
        if (m_stack.size() == DEPTH) evt = 1;
        else m_stack.push_back(m_flags);
      end else if (pop) begin
        if (m_stack.size() == 0) evt = 1;
        else begin popped = m_stack.pop_back(); do_pop = 1; end
      end
      if (msr_we) nf = msr_data;
      else if (do_pop) nf = popped;
      else if (flag_we) nf = alu_nzcv;
      m_exec = cond_valid && cond_true(cond, m_flags);
      if (evt) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
      m_flags = nf;
    end
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    chk("m_nzcv", nzcv_q, m_flags);
    chk("m_c", {3'b0, c_out}, {3'b0, m_flags[1]});
    chk("m_v", {3'b0, v_out}, {3'b0, m_flags[0]});
    chk("m_pass", {3'b0, cond_pass}, {3'b0, cond_true(cond, m_flags)});
    chk("m_exec", {3'b0, exec_en_q}, {3'b0, m_exec});
    chk("m_full", {3'b0, stack_full}, {3'b0, m_stack.size() == DEPTH});
    chk("m_empty", {3'b0, stack_empty}, {3'b0, m_stack.size() == 0});
    chk("m_err", {3'b0, stack_err}, {3'b0, m_err});
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    #2;
  endtask

  task automatic idle();
    flag_we = 0; msr_we = 0; push = 0; pop = 0; err_clr = 0;
  endtask

  logic [3:0] sweep_flags [4] = '{4'b0110, 4'b1001, 4'b1000, 4'b0001};

  initial begin
    cond = 4'hE; cond_valid = 1;
    #12 rst_n = 1;
    @(negedge clk); #2;
    chk("rst_nzcv", nzcv_q, 4'b0000);
    chk("rst_empty", {3'b0, stack_empty}, 4'd1);
    chk("al_pass", {3'b0, cond_pass}, 4'd1);
    cyc();
    chk("al_exec", {3'b0, exec_en_q}, 4'd1);
    cond = 4'h0; #1;
    chk("eq_pass0", {3'b0, cond_pass}, 4'd0);
    cond_valid = 0;

    flag_we = 1; alu_nzcv = 4'b0110;
    cyc(); idle();
    chk("fw_nzcv", nzcv_q, 4'b0110);
    chk("fw_c", {3'b0, c_out}, 4'd1);
    chk("fw_v", {3'b0, v_out}, 4'd0);
    cond = 4'h8; #1; chk("hi_0110", {3'b0, cond_pass}, 4'd0);
    cond = 4'h9; #1; chk("ls_0110", {3'b0, cond_pass}, 4'd1);

    for (int k = 0; k < 4; k++) begin
      msr_we = 1; msr_data = sweep_flags[k];
      cyc(); idle();
      for (int c = 0; c < 16; c++) begin
        cond = 4'(c); cond_valid = c[0];
        if (k == 1 && c == 10) begin #1; chk("ge_1001", {3'b0, cond_pass}, 4'd1); end
        if (k == 2 && c == 11) begin #1; chk("lt_1000", {3'b0, cond_pass}, 4'd1); end
        cyc();
      end
    end
    cond_valid = 0;

    msr_we = 1; msr_data = 4'b1111; flag_we = 1; alu_nzcv = 4'b0000;
    cyc(); idle();
    chk("msr_wins", nzcv_q, 4'b1111);

    for (int k = 0; k < 4; k++) begin
      msr_we = 1; msr_data = 4'(1 << k);
      cyc(); idle();
      push = 1;
      cyc(); idle();
    end
    chk("full", {3'b0, stack_full}, 4'd1);
    push = 1; cyc(); idle();
    chk("push_ovf_err", {3'b0, stack_err}, 4'd1);
    chk("push_ovf_full", {3'b0, stack_full}, 4'd1);
    for (int k = 3; k >= 0; k--) begin
      pop = 1; cyc(); idle();
      chk("pop_val", nzcv_q, 4'(1 << k));
    end
    chk("pop_empty", {3'b0, stack_empty}, 4'd1);
    pop = 1; cyc(); idle();
    chk("pop_udf_hold", nzcv_q, 4'b0001);
    chk("pop_udf_err", {3'b0, stack_err}, 4'd1);
    err_clr = 1; cyc(); idle();
    chk("err_clr", {3'b0, stack_err}, 4'd0);

    // err_clr with simultaneous error: set wins
    pop = 1; err_clr = 1; cyc(); idle();
    chk("set_wins", {3'b0, stack_err}, 4'd1);
    err_clr = 1; cyc(); idle();

    msr_we = 1; msr_data = 4'b0011; cyc(); idle();
    push = 1; flag_we = 1; alu_nzcv = 4'b1100; cyc(); idle();
    chk("pushfw_nzcv", nzcv_q, 4'b1100);
    push = 1; pop = 1; cyc(); idle();
    chk("pp_err", {3'b0, stack_err}, 4'd1);
    chk("pp_hold", nzcv_q, 4'b1100);
    chk("pp_notempty", {3'b0, stack_empty}, 4'd0);
    pop = 1; cyc(); idle();
    chk("pushfw_top", nzcv_q, 4'b0011);
    chk("pushfw_empty", {3'b0, stack_empty}, 4'd1);

    // Async reset in the middle of a push burst
    msr_we = 1; msr_data = 4'b1010; cond = 4'hE; cond_valid = 1; cyc(); idle();
    push = 1; cyc(); cyc();
    #1 rst_n = 0;
    #1;
    chk("ar_nzcv", nzcv_q, RSTF);
    chk("ar_empty", {3'b0, stack_empty}, 4'd1);
    chk("ar_exec", {3'b0, exec_en_q}, 4'd0);
    chk("ar_err", {3'b0, stack_err}, 4'd0);
    idle(); cond_valid = 0;
    cyc();
    rst_n = 1;
    cyc(); cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    bad++;
    $display("FAIL timeout: got no finish expected finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/flag_unit.md
Name: flag_unit

Overview:
Holds the architectural NZCV flag register written from the ALU's NZCV output. Returns the current C and V to the ALU carry/overflow inputs. Evaluates the 4-bit condition field of the instruction in decode against the held flags. Provides a small save/restore stack so the control unit can push flags on exception entry and pop them on return.

Parameters:
DEPTH, 4, number of entries in the flag save stack (power of two, 2..16)
RST_FLAGS, 4'b0000, NZCV value loaded on reset

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
alu_nzcv  input  4  NZCV from ALU, bit3=N bit2=Z bit1=C bit0=V
flag_we  input  1  S-bit: latch alu_nzcv this cycle
msr_we  input  1  direct software write of flags
msr_data  input  4  value for msr_we
push  input  1  save current flags to stack
pop  input  1  restore flags from stack top
err_clr  input  1  clears sticky stack_err
cond  input  4  instruction condition field
cond_valid  input  1  cond qualifies an instruction this cycle
nzcv_q  output  4  current flag register
c_out  output  1  nzcv_q[1], to ALU C input
v_out  output  1  nzcv_q[0], to ALU V input
cond_pass  output  1  combinational condition result on nzcv_q
exec_en_q  output  1  registered cond_valid & cond_pass, one-cycle latency
stack_full  output  1  count == DEPTH
stack_empty  output  1  count == 0
stack_err  output  1  sticky overflow/underflow/illegal-op flag

Behaviour:
- Reset (async, rst_n=0) sets the following, independent of clk:
  - nzcv_q=RST_FLAGS, exec_en_q=0, stack count=0, stack_err=0, stack_empty=1, stack_full=0.
  - Stack RAM contents are not reset.
- Flag register next-value priority, per edge:
  - msr_we: load msr_data.
  - else valid pop: load stack top.
  - else flag_we: load alu_nzcv.
  - else hold.
- push, legal when count<DEPTH and pop=0:
  - Writes the pre-update nzcv_q to entry[count]; count+1.
  - A flag_we or msr_we in the same cycle still updates nzcv_q; the stack receives the old value.
- pop, legal when count>0 and push=0: nzcv_q := entry[count-1]; count-1.
- Illegal stack operations set stack_err; count and entries are unchanged.
  - push while full.
  - pop while empty.
  - push and pop in the same cycle. In this case flag_we and msr_we are still honoured.
- stack_err clearing:
  - err_clr clears stack_err on the next edge.
  - If an error event occurs in the same cycle, the set wins.
- cond_pass, combinational on nzcv_q (not on the incoming alu_nzcv). An instruction issued in the cycle after a flag_we sees the new flags.
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V.
  - 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V); E AL 1; F NV 0.
- exec_en_q <= cond_valid & cond_pass each edge.
- c_out and v_out are direct wires from nzcv_q, with no extra latency.
- Reset asserted mid-stack-operation discards the operation; reset state applies immediately.

Decomposition:
- Shared package holds:
  - Condition code localparams COND_EQ..COND_NV.
  - Flag bit indices F_N=3, F_Z=2, F_C=1, F_V=0, matching the ALU bit order.
  - Width constant NZCV_W=4.
- One sub-module, cond_eval: a pure combinational (cond, nzcv) -> pass function. It is reusable by a future branch unit.
- Stack storage and the count register stay inline.

Test Plan:
- Reset, then cond=E, cond_valid=1 -> nzcv_q=0000, cond_pass=1, exec_en_q=1 after one edge; cond=0 (EQ) -> cond_pass=0.
- flag_we=1, alu_nzcv=0110 (Z,C) -> next cycle nzcv_q=0110, c_out=1, v_out=0. Sweep all 16 cond values on flags 0110, 1001, 1000, 0001 and check against the table: HI=0 and LS=1 on 0110; GE=1 on 1001; LT=1 on 1000.
- Same edge msr_we=1 msr_data=1111, flag_we=1 alu_nzcv=0000 -> nzcv_q=1111 (msr wins).
- DEPTH=4: push with flags 0001,0010,0100,1000 in turn -> stack_full=1.
  - Fifth push -> stack_err=1, count stays 4.
  - Four pops return flags 1000,0100,0010,0001 in order, then stack_empty=1.
  - Fifth pop -> nzcv_q unchanged, stack_err stays 1.
  - err_clr -> stack_err=0.
- push with flag_we alu_nzcv=1100 while nzcv_q=0011 -> stack top=0011, nzcv_q=1100. Next cycle push=pop=1 -> stack_err=1, count unchanged.
- Assert rst_n=0 between clock edges during a push burst -> nzcv_q=RST_FLAGS, stack_empty=1, exec_en_q=0 immediately, without waiting for clk.
